prim_clock_mux_sel_ctrl: RTL



---
 rtl/prim_clock_mux_sel_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prim_clock_mux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// prim_clock_mux_sel_ctrl
//
// Drives the select line of a two-input clock mux and the enable of the clock
// gate that follows it. A switch request is taken over a valid/ready
// handshake and then runs the fixed sequence gate -> switch -> settle ->
// ungate, so the mux select only moves while the muxed clock is gated off.
// A request for the select that is already active completes without gating.
// Completion is flagged by a one-cycle done pulse.
//
// Parameters:
//   GateCycles   cycles spent in GATE and again in UNGATE (>= 1)
//   SettleCycles cycles spent in SWITCH after the select moves (>= 1)
//   ResetSel     select value driven while in reset
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   req_valid_i  switch request valid
//   req_sel_i    requested select (0 -> clk0, 1 -> clk1)
//   req_ready_o  high only in IDLE; handshake when valid && ready
//   sel_o        registered clock mux select
//   clk_en_o     registered downstream clock gate enable
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when a request completes
//
// Every output is a flop. Next-state logic computes the output values for
// the state being entered, so no request input reaches an output without
// passing through a register.
// -----------------------------------------------------------------------------
module prim_clock_mux_sel_ctrl #(
  parameter int unsigned GateCycles   = 4,
  parameter int unsigned SettleCycles = 8,
  parameter logic        ResetSel     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic done_o
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: zero-length phases would break the gate/settle guarantee.
  // ---------------------------------------------------------------------------
  if (GateCycles < 1) begin : g_bad_gate_cycles
    $error("prim_clock_mux_sel_ctrl: GateCycles must be >= 1");
  end
  if (SettleCycles < 1) begin : g_bad_settle_cycles
    $error("prim_clock_mux_sel_ctrl: SettleCycles must be >= 1");
  end

  // Wait counter sized for the longer of the two phase lengths.
  localparam int unsigned MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // Counter is loaded with N-1 on phase entry and the phase ends when it hits
  // zero, giving exactly N cycles in the phase.
  localparam logic [CntW-1:0] GateLoad   = CntW'(GateCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StGate   = 3'd1,
    StSwitch = 3'd2,
    StUngate = 3'd3,
    StDone   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e          state_q,  state_d;
  logic [CntW-1:0] cnt_q,    cnt_d;
  logic            target_q, target_d;
  logic            sel_q,    sel_d;
  logic            clk_en_q, clk_en_d;
  logic            done_q,   done_d;
  logic            busy_q,   busy_d;
  logic            ready_q,  ready_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    clk_en_d = clk_en_q;
    done_d   = 1'b0;
    // Free-running decrement that saturates at zero; phase entries override it.
    cnt_d    = (cnt_q == '0) ? '0 : (cnt_q - CntW'(1));

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (req_sel_i == sel_q) begin
            // Already on the requested clock: skip the gating sequence.
            state_d = StDone;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d  = StGate;
            target_d = req_sel_i;
            clk_en_d = 1'b0;
            cnt_d    = GateLoad;
          end
        end
      end

      StGate: begin
        if (cnt_q == '0) begin
          // Clock has been gated for the full window; safe to move the mux.
          state_d = StSwitch;
          sel_d   = target_q;
          cnt_d   = SettleLoad;
        end
      end

      StSwitch: begin
        if (cnt_q == '0) begin
          state_d  = StUngate;
          clk_en_d = 1'b1;
          cnt_d    = GateLoad;
        end
      end

      StUngate: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end

      default: begin
        // Unreachable encodings recover to a safe, ungated idle.
        state_d  = StIdle;
        clk_en_d = 1'b1;
        cnt_d    = '0;
      end
    endcase

    // Status outputs are decoded from the state being entered so they can
    // be registered alongside it.
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= ResetSel;
      sel_q    <= ResetSel;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready_o = ready_q;
  assign sel_o       = sel_q;
  assign clk_en_o    = clk_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // ---------------------------------------------------------------------------
  // Simulation-only checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // Checks start one clock after reset release so that the first sampled
  // cycle is never a reset cycle.
  logic chk_en_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_en_q <= 1'b0;
    end else begin
      chk_en_q <= 1'b1;
    end
  end

  // A presented request must carry a defined select value.
  a_req_sel_known: assert property (@(posedge clk_i) disable iff (rst_i)
    (chk_en_q && req_valid_i) |-> !$isunknown(req_sel_i))
    else $error("prim_clock_mux_sel_ctrl: req_sel_i is X while req_valid_i is high");

  // The select may only move while the clock is gated, both before and
  // after the edge on which it moves.
  a_sel_only_when_gated: assert property (@(posedge clk_i) disable iff (rst_i)
    (chk_en_q && (sel_q != $past(sel_q))) |-> (!clk_en_q && !$past(clk_en_q)))
    else $error("prim_clock_mux_sel_ctrl: sel_o changed while the clock was enabled");
`endif

endmodule
